ef_apb_wb_irq_bridge: RTL and testbench

Parametrised APB-to-Wishbone bridge with an integrated interrupt manager, used to wrap any Wishbone-slave IP core (I2C, SPI, UART masters) behind the APB fabric. Addresses below 0xFF00 forward to the core over a multi-cycle Wishbone handshake with timeout. The 0xFF00 window holds IM/MIS/RIS/ICR registers for NIRQ per-channel level or edge interrupts.

---
 rtl/ef_apb_bridge_pkg.sv | 22 ++
 rtl/ef_apb_irq_regs.sv | 55 +++++
 rtl/ef_apb_wb_irq_bridge.sv | 211 +++++++++++++++++++++
 tb/tb_ef_apb_wb_irq_bridge.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ef_apb_bridge_pkg.sv
// Shared constants and FSM state type for the APB-to-Wishbone IRQ bridge.
package ef_apb_bridge_pkg;

  // Register window: PADDR[15:8] == RegWinTag, offset in PADDR[7:0].
  localparam logic [7:0] RegWinTag = 8'hFF;

  localparam logic [7:0] OffIm   = 8'h00;
  localparam logic [7:0] OffMis  = 8'h04;
  localparam logic [7:0] OffRis  = 8'h08;
  localparam logic [7:0] OffIcr  = 8'h0C;
  localparam logic [7:0] OffGclk = 8'h10;

  // Returned on Wishbone timeout and on unmapped register reads.
  localparam logic [31:0] ErrData = 32'hDEADBEEF;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StWait = 2'd1,
    StResp = 2'd2
  } state_e;

endpackage

// File: rtl/ef_apb_irq_regs.sv
// Interrupt manager: mask, raw/masked status, W1C clear and registered irq.
// Channels flagged in EdgeMask are rising-edge sticky; the rest follow flags_i.
module ef_apb_irq_regs #(
  parameter int unsigned     NIRQ     = 9,
  parameter logic [NIRQ-1:0] EdgeMask = '0
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic [NIRQ-1:0] flags_i,
  input  logic            im_we_i,
  input  logic            icr_we_i,
  input  logic [NIRQ-1:0] wdata_i,
  output logic [NIRQ-1:0] im_o,
  output logic [NIRQ-1:0] ris_o,
  output logic [NIRQ-1:0] mis_o,
  output logic            irq_o
);

  logic [NIRQ-1:0] im_q, im_d;
  logic [NIRQ-1:0] edge_q, edge_d;
  logic [NIRQ-1:0] hist_q;
  logic            irq_q;

  // Next-state: sticky edge bits, set has priority over a same-cycle clear.
  always_comb begin
    im_d   = im_we_i ? wdata_i : im_q;
    edge_d = edge_q;
    if (icr_we_i) begin
      edge_d = edge_d & ~wdata_i;
    end
    edge_d = (edge_d | (flags_i & ~hist_q)) & EdgeMask;
  end

  // State: mask, edge status, flag history and the registered interrupt.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      im_q   <= '0;
      edge_q <= '0;
      hist_q <= '0;
      irq_q  <= 1'b0;
    end else begin
      im_q   <= im_d;
      edge_q <= edge_d;
      hist_q <= flags_i;
      irq_q  <= |(ris_o & im_q);
    end
  end

  // Level channels mirror the raw flags combinationally.
  assign ris_o = (edge_q & EdgeMask) | (flags_i & ~EdgeMask);
  assign mis_o = ris_o & im_q;
  assign im_o  = im_q;
  assign irq_o = irq_q;

endmodule

// File: rtl/ef_apb_wb_irq_bridge.sv
// APB slave bridging to a Wishbone core, with an interrupt register window at 0xFFxx.
// Optional EF_APB_GCLK_EN: adds the GCLK register whose bit0 gates wb_clk_o.
module ef_apb_wb_irq_bridge
  import ef_apb_bridge_pkg::*;
#(
  parameter int unsigned     DW        = 16,
  parameter int unsigned     AW        = 3,
  parameter int unsigned     NIRQ      = 9,
  parameter logic [NIRQ-1:0] EDGE_MASK = '0,
  parameter int unsigned     TIMEOUT   = 255
) (
  input  logic            PCLK,
  input  logic            PRESETn,
  input  logic [31:0]     PADDR,
  input  logic [31:0]     PWDATA,
  input  logic            PWRITE,
  input  logic            PSEL,
  input  logic            PENABLE,
  output logic            PREADY,
  output logic [31:0]     PRDATA,
  output logic            PSLVERR,
  output logic            wb_clk_o,
  output logic            wbs_cyc_o,
  output logic            wbs_stb_o,
  output logic            wbs_we_o,
  output logic [DW/8-1:0] wbs_sel_o,
  output logic [AW-1:0]   wbs_adr_o,
  output logic [DW-1:0]   wbs_dat_o,
  input  logic [DW-1:0]   wbs_dat_i,
  input  logic            wbs_ack_i,
  input  logic [NIRQ-1:0] flags_i,
  output logic            irq_o
);

  localparam int unsigned   CW   = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] TMax = CW'(TIMEOUT - 1);

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            cyc_q, cyc_d;
  logic            we_q, we_d;
  logic [AW-1:0]   adr_q, adr_d;
  logic [DW-1:0]   dat_q, dat_d;
  logic            pready_q, pready_d;
  logic            pslverr_q, pslverr_d;
  logic [31:0]     prdata_q, prdata_d;
  logic [31:0]     reg_rdata;
  logic [NIRQ-1:0] im, ris, mis;

  logic       access, reg_acc, wb_acc, im_we, icr_we;
  logic [7:0] reg_off;
  logic       unused_bits;

  assign access  = PSEL & PENABLE & (state_q == StIdle);
  assign wb_acc  = access & (PADDR[15:8] != RegWinTag);
  assign reg_acc = access & (PADDR[15:8] == RegWinTag);
  assign reg_off = PADDR[7:0];
  assign im_we   = reg_acc & PWRITE & (reg_off == OffIm);
  assign icr_we  = reg_acc & PWRITE & (reg_off == OffIcr);

  assign unused_bits = ^{PADDR[31:16], PADDR[1:0], PWDATA};

  ef_apb_irq_regs #(
    .NIRQ     (NIRQ),
    .EdgeMask (EDGE_MASK)
  ) u_irq_regs (
    .clk_i    (PCLK),
    .rst_ni   (PRESETn),
    .flags_i  (flags_i),
    .im_we_i  (im_we),
    .icr_we_i (icr_we),
    .wdata_i  (PWDATA[NIRQ-1:0]),
    .im_o     (im),
    .ris_o    (ris),
    .mis_o    (mis),
    .irq_o    (irq_o)
  );

`ifdef EF_APB_GCLK_EN
  logic gclk_q;
  logic gate_en;

  // GCLK enable register, written only through the register window.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      gclk_q <= 1'b0;
    end else if (reg_acc && PWRITE && (reg_off == OffGclk)) begin
      gclk_q <= PWDATA[0];
    end
  end

  // Latch-based gate: enable only changes while PCLK is low, so no glitches.
  always_latch begin
    if (!PCLK) begin
      gate_en = gclk_q;
    end
  end

  assign wb_clk_o = PCLK & gate_en;
`else
  assign wb_clk_o = PCLK;
`endif

  // Register-window read mux.
  always_comb begin
    reg_rdata = ErrData;
    case (reg_off)
      OffIm:   reg_rdata = 32'(im);
      OffMis:  reg_rdata = 32'(mis);
      OffRis:  reg_rdata = 32'(ris);
      OffIcr:  reg_rdata = '0;
`ifdef EF_APB_GCLK_EN
      OffGclk: reg_rdata = {31'b0, gclk_q};
`else
      OffGclk: reg_rdata = '0;
`endif
      default: ;
    endcase
  end

  // Bridge FSM next-state: IDLE dispatches, WAIT runs the WB cycle, RESP pulses PREADY.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    cyc_d     = cyc_q;
    we_d      = we_q;
    adr_d     = adr_q;
    dat_d     = dat_q;
    pready_d  = 1'b0;
    pslverr_d = pslverr_q;
    prdata_d  = prdata_q;
    unique case (state_q)
      StIdle: begin
        pslverr_d = 1'b0;
        if (wb_acc) begin
          state_d = StWait;
          cyc_d   = 1'b1;
          we_d    = PWRITE;
          adr_d   = PADDR[AW+1:2];
          dat_d   = PWDATA[DW-1:0];
          cnt_d   = '0;
        end else if (reg_acc) begin
          state_d  = StResp;
          pready_d = 1'b1;
          prdata_d = PWRITE ? '0 : reg_rdata;
        end
      end
      StWait: begin
        if (wbs_ack_i) begin
          state_d   = StResp;
          cyc_d     = 1'b0;
          pready_d  = 1'b1;
          pslverr_d = 1'b0;
          prdata_d  = we_q ? '0 : 32'(wbs_dat_i);
        end else if (cnt_q == TMax) begin
          state_d   = StResp;
          cyc_d     = 1'b0;
          pready_d  = 1'b1;
          pslverr_d = 1'b1;
          prdata_d  = ErrData;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      StResp: begin
        state_d   = StIdle;
        pslverr_d = 1'b0;
      end
      default: begin
        state_d = StIdle;
        cyc_d   = 1'b0;
      end
    endcase
  end

  // Bridge state; async reset drops an in-flight WB cycle at once.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      cyc_q     <= 1'b0;
      we_q      <= 1'b0;
      adr_q     <= '0;
      dat_q     <= '0;
      pready_q  <= 1'b0;
      pslverr_q <= 1'b0;
      prdata_q  <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      cyc_q     <= cyc_d;
      we_q      <= we_d;
      adr_q     <= adr_d;
      dat_q     <= dat_d;
      pready_q  <= pready_d;
      pslverr_q <= pslverr_d;
      prdata_q  <= prdata_d;
    end
  end

  assign PREADY    = pready_q;
  assign PRDATA    = prdata_q;
  assign PSLVERR   = pslverr_q;
  assign wbs_cyc_o = cyc_q;
  assign wbs_stb_o = cyc_q;
  assign wbs_we_o  = we_q;
  assign wbs_adr_o = adr_q;
  assign wbs_dat_o = dat_q;
  assign wbs_sel_o = '1;

endmodule

// File: tb/tb_ef_apb_wb_irq_bridge.sv
// Directed bench for ef_apb_wb_irq_bridge (DW=16, AW=3, NIRQ=9, edge on ch0, TIMEOUT=4).
module tb_ef_apb_wb_irq_bridge;

  logic        clk;
  logic        rst_n;
  logic [31:0] PADDR, PWDATA;
  logic        PWRITE, PSEL, PENABLE;
  logic        PREADY, PSLVERR;
  logic [31:0] PRDATA;
  logic        wb_clk;
  logic        cyc, stb, we;
  logic [1:0]  sel;
  logic [2:0]  adr;
  logic [15:0] dat_o, dat_i;
  logic        ack;
  logic [8:0]  flags;
  logic        irq;

  int checks   = 0;
  int failures = 0;

  ef_apb_wb_irq_bridge #(
    .DW        (16),
    .AW        (3),
    .NIRQ      (9),
    .EDGE_MASK (9'h001),
    .TIMEOUT   (4)
  ) dut (
    .PCLK      (clk),
    .PRESETn   (rst_n),
    .PADDR     (PADDR),
    .PWDATA    (PWDATA),
    .PWRITE    (PWRITE),
    .PSEL      (PSEL),
    .PENABLE   (PENABLE),
    .PREADY    (PREADY),
    .PRDATA    (PRDATA),
    .PSLVERR   (PSLVERR),
    .wb_clk_o  (wb_clk),
    .wbs_cyc_o (cyc),
    .wbs_stb_o (stb),
    .wbs_we_o  (we),
    .wbs_sel_o (sel),
    .wbs_adr_o (adr),
    .wbs_dat_o (dat_o),
    .wbs_dat_i (dat_i),
    .wbs_ack_i (ack),
    .flags_i   (flags),
    .irq_o     (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One APB transfer; lat = cycles from access phase until PREADY observed.
  task automatic apb_xfer(input logic [31:0] addr, input logic [31:0] wdata, input logic wr,
                          output logic [31:0] rdata, output logic err, output int lat);
    @(posedge clk); #1;
    PADDR = addr; PWDATA = wdata; PWRITE = wr; PSEL = 1'b1; PENABLE = 1'b0;
    @(posedge clk); #1;
    PENABLE = 1'b1;
    lat = 0; rdata = '0; err = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      lat++;
      if (PREADY) begin
        rdata = PRDATA;
        err   = PSLVERR;
        break;
      end
    end
    if (!PREADY) begin
      checks++; failures++;
      $display("FAIL apb_pready_wait addr=%h got no PREADY within 20 cycles", addr);
    end
    PSEL = 1'b0; PENABLE = 1'b0;
  endtask

  // Wishbone slave: acks during the ack_at-th cycle of cyc (0 = never), records bus fields.
  task automatic wb_slave(input int ack_at, input logic [15:0] rd, output int cyc_cnt,
                          output logic [2:0] a, output logic [15:0] d, output logic w);
    cyc_cnt = 0; a = '0; d = '0; w = 1'b0;
    for (int i = 0; i < 14; i++) begin
      @(posedge clk); #1;
      ack = 1'b0;
      if (cyc) begin
        cyc_cnt++;
        a = adr; d = dat_o; w = we;
        if (cyc_cnt == ack_at) begin
          ack   = 1'b1;
          dat_i = rd;
        end
      end
    end
    ack = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] rd; logic er; int lat;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (PREADY !== 1'b0) begin failures++; $display("FAIL rst_pready got=%b exp=0", PREADY); end
    checks++; if (PRDATA !== 32'h0) begin failures++; $display("FAIL rst_prdata got=%h exp=0", PRDATA); end
    checks++; if ({PSLVERR, cyc, stb, we, irq} !== 5'b0) begin
      failures++; $display("FAIL rst_ctrl got=%b exp=00000", {PSLVERR, cyc, stb, we, irq});
    end
    checks++; if ({adr, dat_o} !== 19'h0) begin
      failures++; $display("FAIL rst_bus got adr=%h dat=%h exp 0", adr, dat_o);
    end
    checks++; if (sel !== 2'b11) begin failures++; $display("FAIL sel got=%b exp=11", sel); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    apb_xfer(32'h0000_FF00, 32'h0, 1'b0, rd, er, lat);
    checks++; if (rd !== 32'h0 || er !== 1'b0 || lat != 1) begin
      failures++; $display("FAIL rst_im_read got=%h err=%b lat=%0d exp 0/0/1", rd, er, lat);
    end
    apb_xfer(32'h0000_FF08, 32'h0, 1'b0, rd, er, lat);
    checks++; if (rd !== 32'h0 || lat != 1) begin
      failures++; $display("FAIL rst_ris_read got=%h lat=%0d exp 0/1", rd, lat);
    end
    checks++; if (irq !== 1'b0) begin failures++; $display("FAIL rst_irq got=%b exp=0", irq); end
  endtask

  task automatic test_wb_read();
    logic [31:0] rd; logic er; int lat; int cc; logic [2:0] a; logic [15:0] d; logic w;
    fork
      apb_xfer(32'h0000_0004, 32'h0, 1'b0, rd, er, lat);
      wb_slave(3, 16'hA5C3, cc, a, d, w);
    join
    checks++; if (a !== 3'd1 || w !== 1'b0) begin
      failures++; $display("FAIL wb_read_bus got adr=%0d we=%b exp 1/0", a, w);
    end
    checks++; if (rd !== 32'h0000_A5C3 || er !== 1'b0) begin
      failures++; $display("FAIL wb_read_data got=%h err=%b exp 0000a5c3/0", rd, er);
    end
    checks++; if (lat != 4 || cc != 3) begin
      failures++; $display("FAIL wb_read_lat got lat=%0d cyc=%0d exp 4/3", lat, cc);
    end
  endtask

  task automatic test_wb_write();
    logic [31:0] rd; logic er; int lat; int cc; logic [2:0] a; logic [15:0] d; logic w;
    fork
      apb_xfer(32'h0000_0008, 32'h1234_5678, 1'b1, rd, er, lat);
      wb_slave(1, 16'hFFFF, cc, a, d, w);
    join
    checks++; if (d !== 16'h5678 || w !== 1'b1 || a !== 3'd2) begin
      failures++; $display("FAIL wb_write_bus got dat=%h we=%b adr=%0d exp 5678/1/2", d, w, a);
    end
    checks++; if (lat != 2 || er !== 1'b0 || rd !== 32'h0) begin
      failures++; $display("FAIL wb_write_resp got lat=%0d err=%b rd=%h exp 2/0/0", lat, er, rd);
    end
  endtask

  task automatic test_timeout();
    logic [31:0] rd; logic er; int lat; int cc; logic [2:0] a; logic [15:0] d; logic w;
    fork
      apb_xfer(32'h0000_000C, 32'h0, 1'b0, rd, er, lat);
      wb_slave(0, 16'h0, cc, a, d, w);
    join
    checks++; if (cc != 4) begin failures++; $display("FAIL timeout_cyc got=%0d exp=4", cc); end
    checks++; if (er !== 1'b1 || rd !== 32'hDEADBEEF || lat != 5) begin
      failures++; $display("FAIL timeout_resp got err=%b rd=%h lat=%0d exp 1/deadbeef/5", er, rd, lat);
    end
    checks++; if (cyc !== 1'b0 || stb !== 1'b0) begin
      failures++; $display("FAIL timeout_drop got cyc=%b stb=%b exp 0/0", cyc, stb);
    end
  endtask

  task automatic test_reg_misc();
    logic [31:0] rd; logic er; int lat;
    apb_xfer(32'h0000_FF20, 32'h0, 1'b0, rd, er, lat);
    checks++; if (rd !== 32'hDEADBEEF || er !== 1'b0) begin
      failures++; $display("FAIL unmapped_read got=%h err=%b exp deadbeef/0", rd, er);
    end
    apb_xfer(32'h0000_FF10, 32'h0, 1'b0, rd, er, lat);
    checks++; if (rd !== 32'h0) begin failures++; $display("FAIL gclk_reset got=%h exp=0", rd); end
    apb_xfer(32'h0000_FF10, 32'h1, 1'b1, rd, er, lat);
    apb_xfer(32'h0000_FF10, 32'h0, 1'b0, rd, er, lat);
`ifdef EF_APB_GCLK_EN
    checks++; if (rd !== 32'h1) begin failures++; $display("FAIL gclk_rw got=%h exp=1", rd); end
    @(negedge clk); #1;
    checks++; if (wb_clk !== 1'b0) begin failures++; $display("FAIL wb_clk_low got=%b exp=0", wb_clk); end
    @(posedge clk); #1;
    checks++; if (wb_clk !== 1'b1) begin failures++; $display("FAIL wb_clk_on got=%b exp=1", wb_clk); end
`else
    checks++; if (rd !== 32'h0) begin failures++; $display("FAIL gclk_absent got=%h exp=0", rd); end
    @(posedge clk); #1;
    checks++; if (wb_clk !== 1'b1) begin failures++; $display("FAIL wb_clk_pass got=%b exp=1", wb_clk); end
`endif
  endtask

  task automatic pulse_ch0();
    @(posedge clk); #1; flags[0] = 1'b1;
    @(posedge clk); #1; flags[0] = 1'b0;
  endtask

  task automatic test_edge_irq();
    logic [31:0] rd; logic er; int lat;
    apb_xfer(32'h0000_FF00, 32'h0000_0001, 1'b1, rd, er, lat);
    pulse_ch0();
    @(posedge clk); #1;
    checks++; if (irq !== 1'b1) begin failures++; $display("FAIL edge_irq_set got=%b exp=1", irq); end
    apb_xfer(32'h0000_FF08, 32'h0, 1'b0, rd, er, lat);
    checks++; if (rd !== 32'h001) begin failures++; $display("FAIL edge_ris got=%h exp=001", rd); end
    apb_xfer(32'h0000_FF04, 32'h0, 1'b0, rd, er, lat);
    checks++; if (rd !== 32'h001) begin failures++; $display("FAIL edge_mis got=%h exp=001", rd); end
    apb_xfer(32'h0000_FF0C, 32'h0000_0001, 1'b1, rd, er, lat);
    apb_xfer(32'h0000_FF08, 32'h0, 1'b0, rd, er, lat);
    checks++; if (rd !== 32'h0 || irq !== 1'b0) begin
      failures++; $display("FAIL edge_clear got ris=%h irq=%b exp 0/0", rd, irq);
    end
    // Re-arm, then clear in the same cycle as a new rising edge.
    pulse_ch0();
    @(posedge clk); #1;
    PADDR = 32'h0000_FF0C; PWDATA = 32'h1; PWRITE = 1'b1; PSEL = 1'b1; PENABLE = 1'b0;
    @(posedge clk); #1;
    PENABLE = 1'b1; flags[0] = 1'b1;
    @(posedge clk); #1;
    checks++; if (PREADY !== 1'b1) begin failures++; $display("FAIL reg_pready got=%b exp=1", PREADY); end
    PSEL = 1'b0; PENABLE = 1'b0; flags[0] = 1'b0;
    apb_xfer(32'h0000_FF08, 32'h0, 1'b0, rd, er, lat);
    checks++; if (rd !== 32'h001 || irq !== 1'b1) begin
      failures++; $display("FAIL edge_set_wins got ris=%h irq=%b exp 001/1", rd, irq);
    end
    apb_xfer(32'h0000_FF0C, 32'h0000_0001, 1'b1, rd, er, lat);
    apb_xfer(32'h0000_FF0C, 32'h0, 1'b0, rd, er, lat);
    checks++; if (rd !== 32'h0) begin failures++; $display("FAIL icr_read got=%h exp=0", rd); end
  endtask

  task automatic test_level_irq();
    logic [31:0] rd; logic er; int lat;
    apb_xfer(32'h0000_FF00, 32'h0000_0008, 1'b1, rd, er, lat);
    @(posedge clk); #1; flags[3] = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (irq !== 1'b1) begin failures++; $display("FAIL level_irq got=%b exp=1", irq); end
    apb_xfer(32'h0000_FF0C, 32'h0000_0008, 1'b1, rd, er, lat);
    apb_xfer(32'h0000_FF08, 32'h0, 1'b0, rd, er, lat);
    checks++; if (rd !== 32'h008 || irq !== 1'b1) begin
      failures++; $display("FAIL level_icr_ignored got ris=%h irq=%b exp 008/1", rd, irq);
    end
    @(posedge clk); #1; flags[3] = 1'b0;
    @(posedge clk); #1;
    checks++; if (irq !== 1'b0) begin failures++; $display("FAIL level_drop got=%b exp=0", irq); end
  endtask

  task automatic test_reset_mid_wait();
    logic [31:0] rd; logic er; int lat;
    @(posedge clk); #1;
    PADDR = 32'h0000_0000; PWRITE = 1'b0; PSEL = 1'b1; PENABLE = 1'b0;
    @(posedge clk); #1;
    PENABLE = 1'b1;
    @(posedge clk); #1;
    checks++; if (cyc !== 1'b1) begin failures++; $display("FAIL mid_wait_cyc got=%b exp=1", cyc); end
    #3 rst_n = 1'b0;
    #1;
    checks++; if (cyc !== 1'b0 || stb !== 1'b0) begin
      failures++; $display("FAIL async_drop got cyc=%b stb=%b exp 0/0", cyc, stb);
    end
    PSEL = 1'b0; PENABLE = 1'b0;
    @(posedge clk); #1; rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (PREADY !== 1'b0 || cyc !== 1'b0) begin
      failures++; $display("FAIL post_reset got pready=%b cyc=%b exp 0/0", PREADY, cyc);
    end
    apb_xfer(32'h0000_FF00, 32'h0, 1'b0, rd, er, lat);
    checks++; if (rd !== 32'h0) begin failures++; $display("FAIL im_after_reset got=%h exp=0", rd); end
  endtask

  initial begin
    rst_n = 1'b0; PADDR = '0; PWDATA = '0; PWRITE = 1'b0; PSEL = 1'b0; PENABLE = 1'b0;
    dat_i = '0; ack = 1'b0; flags = '0;
    test_reset();
    test_wb_read();
    test_wb_write();
    test_timeout();
    test_reg_misc();
    test_edge_irq();
    test_level_irq();
    test_reset_mid_wait();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
